// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage MIPS core.
// Carries decoded operands and control into EX, detects load-use hazards
// (stalling IF/ID), forwards MEM/WB results onto the EX operands, and
// honours flush (branch redirect) and ex_hold (multi-cycle EX busy).
//
// Build option: define ID_EX_FWD_EN to enable MEM/WB forwarding. Without it
// the operands are the raw stored values and the stall covers every in-flight
// EX or MEM producer instead (WB is covered by the register file bypass).
module id_ex_stage #(
  parameter int N  = 5,
  parameter int M  = 32,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [N-1:0]  id_rs,
  input  logic [N-1:0]  id_rt,
  input  logic [N-1:0]  id_dst,
  input  logic [M-1:0]  id_rd1,
  input  logic [M-1:0]  id_rd2,
  input  logic [M-1:0]  id_imm,
  input  logic [CW-1:0] id_ctrl,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic          mem_regwrite,
  input  logic [N-1:0]  mem_dst,
  input  logic [M-1:0]  mem_result,
  input  logic          wb_regwrite,
  input  logic [N-1:0]  wb_dst,
  input  logic [M-1:0]  wb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic [N-1:0]  ex_rs,
  output logic [N-1:0]  ex_rt,
  output logic [N-1:0]  ex_dst,
  output logic [M-1:0]  ex_a,
  output logic [M-1:0]  ex_b,
  output logic [M-1:0]  ex_imm,
  output logic [CW-1:0] ex_ctrl
);

  // EX-side pipeline register
  logic          r_valid;
  logic          r_regwrite;
  logic          r_memread;
  logic [N-1:0]  r_rs;
  logic [N-1:0]  r_rt;
  logic [N-1:0]  r_dst;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-1:0]  r_imm;
  logic [CW-1:0] r_ctrl;

  logic [M-1:0]  w_ex_a;
  logic [M-1:0]  w_ex_b;
  logic          w_ex_hit;
  logic          w_load_use;
  logic          w_hazard;

  // Does the instruction sitting in EX write a register the ID instruction reads?
  assign w_ex_hit   = (r_dst != '0) && ((r_dst == id_rs) || (r_dst == id_rt));
  assign w_load_use = id_valid && r_valid && r_memread && w_ex_hit;

`ifdef ID_EX_FWD_EN
  // Operand A bypass: MEM is younger than WB, so it wins; $0 never forwards.
  always_comb begin
    // NOTE: assign a default first so every path drives the output and no latch is inferred.
    w_ex_a = r_a;
    if (mem_regwrite && (mem_dst == r_rs) && (r_rs != '0)) begin
      w_ex_a = mem_result;
    end else if (wb_regwrite && (wb_dst == r_rs) && (r_rs != '0)) begin
      w_ex_a = wb_data;
    end
  end

  // Operand B bypass, same priority as operand A.
  always_comb begin
    w_ex_b = r_b;
    if (mem_regwrite && (mem_dst == r_rt) && (r_rt != '0)) begin
      w_ex_b = mem_result;
    end else if (wb_regwrite && (wb_dst == r_rt) && (r_rt != '0)) begin
      w_ex_b = wb_data;
    end
  end

  // With forwarding, only a load in EX cannot be bypassed in time.
  assign w_hazard = w_load_use;
`else
  logic w_mem_hit;
  logic w_unused_fwd;

  // Without forwarding the operands come straight from the pipeline register.
  assign w_ex_a = r_a;
  assign w_ex_b = r_b;

  // Any EX or MEM producer of a source register must drain before ID may issue.
  assign w_mem_hit = (mem_dst != '0) && ((mem_dst == id_rs) || (mem_dst == id_rt));
  assign w_hazard  = w_load_use
                   || (id_valid && r_valid && (r_regwrite || r_memread) && w_ex_hit)
                   || (id_valid && mem_regwrite && w_mem_hit);

  // Bypass data inputs have no consumer in this build.
  assign w_unused_fwd = ^{mem_result, wb_regwrite, wb_dst, wb_data};
`endif

  // Stall priority: hold freezes IF/ID, a flush cancels the ID instruction anyway.
  always_comb begin
    stall = 1'b0;
    if (ex_hold) begin
      stall = 1'b1;
    end else if (flush) begin
      stall = 1'b0;
    end else begin
      stall = w_hazard;
    end
  end

  // Pipeline register update: reset > hold > flush > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dst      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_ctrl     <= '0;
    end else if (ex_hold) begin
      // Keep the instruction but latch the bypassed operands so a value
      // leaving WB during the hold is not lost.
      r_a <= w_ex_a;
      r_b <= w_ex_b;
    end else if (flush || w_hazard) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else begin
      r_valid    <= id_valid;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_dst      <= id_dst;
      r_a        <= id_rd1;
      r_b        <= id_rd2;
      r_imm      <= id_imm;
      r_ctrl     <= id_ctrl;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_dst      = r_dst;
  assign ex_a        = w_ex_a;
  assign ex_b        = w_ex_b;
  assign ex_imm      = r_imm;
  assign ex_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by random traffic,
// compared against a behavioural model of the EX slot. The model follows the
// ID_EX_FWD_EN build option of the design under test.
module tb_id_ex_stage;
  localparam int N  = 5;
  localparam int M  = 32;
  localparam int CW = 12;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_regwrite, id_memread;
  logic [N-1:0]  id_rs, id_rt, id_dst;
  logic [M-1:0]  id_rd1, id_rd2, id_imm;
  logic [CW-1:0] id_ctrl;
  logic          flush, ex_hold;
  logic          mem_regwrite, wb_regwrite;
  logic [N-1:0]  mem_dst, wb_dst;
  logic [M-1:0]  mem_result, wb_data;
  logic          stall, ex_valid, ex_regwrite, ex_memread;
  logic [N-1:0]  ex_rs, ex_rt, ex_dst;
  logic [M-1:0]  ex_a, ex_b, ex_imm;
  logic [CW-1:0] ex_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.N(N), .M(M), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .ex_hold(ex_hold),
    .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
  );

  // Model of the instruction occupying EX; m_known=0 after a flush/bubble,
  // when the payload fields are unspecified.
  typedef struct {
    bit            valid, regwrite, memread, known;
    logic [N-1:0]  rs, rt, dst;
    logic [M-1:0]  a, b, imm;
    logic [CW-1:0] ctrl;
  } slot_t;
  slot_t m;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.regwrite = 0; s.memread = 0; s.known = 1;
    s.rs = '0; s.rt = '0; s.dst = '0;
    s.a = '0; s.b = '0; s.imm = '0; s.ctrl = '0;
    return s;
  endfunction

  // Value EX actually sees for a source register given the in-flight producers.
  function automatic logic [M-1:0] fwd(input logic [N-1:0] r, input logic [M-1:0] stored);
    if (FWD && r != 0) begin
      if (mem_regwrite && mem_dst == r) return mem_result;
      if (wb_regwrite && wb_dst == r) return wb_data;
    end
    return stored;
  endfunction

  function automatic bit reads(input logic [N-1:0] d);
    return d != 0 && (d == id_rs || d == id_rt);
  endfunction

  function automatic bit hazard();
    if (!id_valid) return 0;
    if (m.valid && m.memread && reads(m.dst)) return 1;
    if (!FWD && m.valid && m.regwrite && reads(m.dst)) return 1;
    if (!FWD && mem_regwrite && reads(mem_dst)) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (ex_hold) return 1;
    if (flush) return 0;
    return hazard();
  endfunction

  task automatic check_comb(input string where);
    chk({where, ".stall"}, 32'(stall), 32'(exp_stall()));
    if (m.known) begin
      chk({where, ".ex_a"}, ex_a, fwd(m.rs, m.a));
      chk({where, ".ex_b"}, ex_b, fwd(m.rt, m.b));
    end
  endtask

  task automatic check_regs(input string where);
    chk({where, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({where, ".ex_regwrite"}, 32'(ex_regwrite), 32'(m.regwrite));
    chk({where, ".ex_memread"}, 32'(ex_memread), 32'(m.memread));
    if (m.known) begin
      chk({where, ".ex_rs"}, 32'(ex_rs), 32'(m.rs));
      chk({where, ".ex_rt"}, 32'(ex_rt), 32'(m.rt));
      chk({where, ".ex_dst"}, 32'(ex_dst), 32'(m.dst));
      chk({where, ".ex_imm"}, ex_imm, m.imm);
      chk({where, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
    end
  endtask

  // One clock: check combinational outputs, advance the model, check again.
  task automatic step(input string where);
    logic [M-1:0] na, nb;
    bit haz;
    #1;
    check_comb({where, ".pre"});
    na  = fwd(m.rs, m.a);
    nb  = fwd(m.rt, m.b);
    haz = hazard();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m = empty_slot();
    end else if (ex_hold) begin
      m.a = na;
      m.b = nb;
    end else if (flush || haz) begin
      m.valid = 0; m.regwrite = 0; m.memread = 0; m.known = 0;
    end else begin
      m.valid = id_valid; m.regwrite = id_regwrite; m.memread = id_memread;
      m.rs = id_rs; m.rt = id_rt; m.dst = id_dst;
      m.a = id_rd1; m.b = id_rd2; m.imm = id_imm; m.ctrl = id_ctrl;
      m.known = 1;
    end
    check_regs({where, ".post"});
    check_comb({where, ".post"});
  endtask

  task automatic set_id(input bit v, input logic [N-1:0] rs, input logic [N-1:0] rt,
                        input logic [N-1:0] dst, input logic [M-1:0] rd1,
                        input logic [M-1:0] rd2, input bit rw, input bit mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rd1 = rd1; id_rd2 = rd2; id_regwrite = rw; id_memread = mr;
    id_imm = $urandom; id_ctrl = CW'($urandom);
  endtask

  task automatic set_prod(input bit mrw, input logic [N-1:0] md, input logic [M-1:0] mres,
                          input bit wrw, input logic [N-1:0] wd, input logic [M-1:0] wdat);
    mem_regwrite = mrw; mem_dst = md; mem_result = mres;
    wb_regwrite = wrw; wb_dst = wd; wb_data = wdat;
  endtask

  // Asynchronous reset pulse launched away from the clock edge.
  task automatic do_reset(input string where);
    rst_n = 1'b0;
    #1;
    m = empty_slot();
    check_regs({where, ".async"});
    check_comb({where, ".async"});
    @(posedge clk);
    #1;
    check_regs({where, ".held"});
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; ex_hold = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_prod(0, 0, 0, 0, 0, 0);
    m = empty_slot();

    // Reset state
    #2;
    check_regs("reset");
    chk("reset.ex_a", ex_a, 32'h0);
    chk("reset.stall", 32'(stall), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Pass-through
    set_id(1, 3, 0, 7, 32'h11, 32'h22, 1, 0);
    id_imm = 32'h4;
    step("pass");
    chk("pass.ex_valid", 32'(ex_valid), 32'h1);
    chk("pass.ex_a", ex_a, 32'h11);
    chk("pass.ex_imm", ex_imm, 32'h4);
    chk("pass.stall", 32'(stall), 32'h0);

    // Forward priority: MEM over WB, then WB alone
    set_id(1, 5, 6, 9, 32'h01, 32'h02, 1, 0);
    step("fwd_cap");
    id_valid = 0;
    set_prod(1, 5, 32'hAA, 1, 5, 32'hBB);
    #1 check_comb("fwd_both");
    mem_regwrite = 0;
    #1 check_comb("fwd_wb");
    set_prod(0, 0, 0, 0, 0, 0);

    // Load-use: lw r4 in EX, consumer reads rt=4
    set_id(1, 1, 2, 4, 32'h3, 32'h4, 1, 1);
    step("lw_cap");
    set_id(1, 6, 4, 8, 32'h66, 32'h99, 1, 0);
    #1 chk("lu.stall", 32'(stall), 32'h1);
    step("lu_bubble");
    chk("lu.ex_valid", 32'(ex_valid), 32'h0);
    set_prod(1, 4, 32'h77, 0, 0, 0);
    step("lu_next");
    step("lu_next2");
    set_prod(0, 0, 0, 0, 0, 0);

    // Register $0: load and producer with dst=0
    set_id(1, 1, 2, 0, 32'h5, 32'h6, 1, 1);
    step("r0_cap");
    set_id(1, 0, 0, 3, 32'h12, 32'h34, 1, 0);
    set_prod(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    #1 chk("r0.stall", 32'(stall), 32'h0);
    step("r0_step");
    set_prod(0, 0, 0, 0, 0, 0);

    // Hold refresh: WB value present only in the first hold cycle
    set_id(1, 5, 7, 2, 32'h10, 32'h20, 1, 0);
    step("hold_cap");
    id_valid = 0;
    ex_hold = 1;
    set_prod(0, 0, 0, 1, 5, 32'h55);
    step("hold1");
    wb_regwrite = 0;
    step("hold2");
    ex_hold = 0;
    step("hold_rel");

    // Flush together with a load-use hazard
    set_id(1, 1, 2, 4, 32'h3, 32'h4, 1, 1);
    step("fl_cap");
    set_id(1, 4, 0, 8, 32'h1, 32'h2, 1, 0);
    flush = 1;
    #1 chk("flush.stall", 32'(stall), 32'h0);
    step("flush");
    chk("flush.ex_valid", 32'(ex_valid), 32'h0);
    flush = 0;

    // Mid-stream reset
    set_id(1, 2, 3, 5, 32'hAB, 32'hCD, 1, 0);
    step("pre_rst");
    do_reset("midrst");
    chk("midrst.ex_a", ex_a, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset("rnd_rst");
      set_id($urandom_range(0, 3) != 0, N'($urandom_range(0, 3)), N'($urandom_range(0, 3)),
             N'($urandom_range(0, 3)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_prod(1'($urandom_range(0, 1)), N'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), N'($urandom_range(0, 3)), $urandom);
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
